// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: datapath/memory handshake bundle between the sequencer and its surroundings
interface multicycle_ctrl_if #(parameter int CNT_W = 32);
  logic [6:0] opcode;
  logic zero;
  logic mem_ready;
  logic mem_read;
  logic mem_write;
  logic iord;
  logic ir_write;
  logic pc_write;
  logic pc_write_cond;
  logic pc_src;
  logic alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic reg_write;
  logic mem_to_reg;
  logic illegal;
  logic [2:0] state;
  logic [CNT_W-1:0] instret;
  modport master (
    output opcode, zero, mem_ready,
    input mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_src,
    input alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, illegal, state, instret
  );
  modport slave (
    input opcode, zero, mem_ready,
    output mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_src,
    output alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, illegal, state, instret
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for the RV64 multi-cycle datapath
module multicycle_ctrl #(parameter int CNT_W = 32) (
  input logic clk,
  input logic reset,
  multicycle_ctrl_if.slave bus
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4} state_e;
  state_e state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic retire, is_r, is_i, is_ld, is_st, is_br, legal;
  assign is_r = bus.opcode == 7'b0110011;
  assign is_i = bus.opcode == 7'b0010011;
  assign is_ld = bus.opcode == 7'b0000011;
  assign is_st = bus.opcode == 7'b0100011;
  assign is_br = bus.opcode == 7'b1100011;
  assign legal = is_r | is_i | is_ld | is_st | is_br;
  assign instret_d = instret_q + CNT_W'(retire);
  assign bus.state = state_q;
  assign bus.instret = instret_q;
  // Whole decode is gated by reset so every strobe is quiet while reset is held.
  always_comb begin
    state_d = FETCH;
    retire = 1'b0;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.iord = 1'b0;
    bus.ir_write = 1'b0;
    bus.pc_write = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.pc_src = 1'b0;
    bus.alu_src_a = 1'b0;
    bus.alu_src_b = 2'b00;
    bus.alu_op = 2'b00;
    bus.reg_write = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.illegal = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          bus.mem_read = 1'b1;
          bus.alu_src_b = 2'b01;
          bus.ir_write = bus.mem_ready;
          bus.pc_write = bus.mem_ready;
          state_d = bus.mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          bus.alu_src_b = 2'b10;
          bus.illegal = !legal;
          retire = !legal;
          state_d = legal ? EXEC : FETCH;
        end
        EXEC: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = (is_r || is_br) ? 2'b00 : 2'b10;
          bus.alu_op = is_br ? 2'b01 : (is_r || is_i) ? 2'b10 : 2'b00;
          bus.pc_write_cond = is_br;
          bus.pc_src = is_br;
          retire = is_br;
          state_d = (is_ld || is_st) ? MEM : (is_r || is_i) ? WB : FETCH;
        end
        MEM: begin
          bus.iord = 1'b1;
          bus.mem_read = is_ld;
          bus.mem_write = is_st;
          retire = is_st && bus.mem_ready;
          state_d = !bus.mem_ready ? MEM : is_ld ? WB : FETCH;
        end
        WB: begin
          bus.reg_write = 1'b1;
          bus.mem_to_reg = is_ld;
          retire = 1'b1;
        end
        default: state_d = FETCH;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    state_q <= reset ? FETCH : state_d;
    instret_q <= reset ? '0 : instret_d;
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: per-cycle scoreboard of strobe vectors and retired counts for multicycle_ctrl
module tb_multicycle_ctrl;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_BAD = 7'b1111111;
  // state | mr mw iord irw pcw pcwc pcsrc | asa | asb | aop | rw m2r ill
  localparam logic [17:0] RST0    = 18'b000_0000000_0_00_00_000;
  localparam logic [17:0] RST_MEM = 18'b011_0000000_0_00_00_000;
  localparam logic [17:0] F_IDLE  = 18'b000_1000000_0_01_00_000;
  localparam logic [17:0] F_RDY   = 18'b000_1001100_0_01_00_000;
  localparam logic [17:0] DEC     = 18'b001_0000000_0_10_00_000;
  localparam logic [17:0] DEC_ILL = 18'b001_0000000_0_10_00_001;
  localparam logic [17:0] EX_R    = 18'b010_0000000_1_00_10_000;
  localparam logic [17:0] EX_I    = 18'b010_0000000_1_10_10_000;
  localparam logic [17:0] EX_LS   = 18'b010_0000000_1_10_00_000;
  localparam logic [17:0] EX_BR   = 18'b010_0000011_1_00_01_000;
  localparam logic [17:0] MEM_LD  = 18'b011_1010000_0_00_00_000;
  localparam logic [17:0] MEM_ST  = 18'b011_0110000_0_00_00_000;
  localparam logic [17:0] WB_R    = 18'b100_0000000_0_00_00_100;
  localparam logic [17:0] WB_LD   = 18'b100_0000000_0_00_00_110;
  typedef struct {logic rst; logic [6:0] op; logic z; logic rdy; logic [17:0] v; logic ret;} stim_t;
  typedef struct {logic [17:0] v; logic [31:0] cnt;} exp_t;
  logic clk = 1'b0;
  logic reset;
  int checks = 0, passed = 0, cyc = 0;
  logic [31:0] cnt = 0;
  stim_t stim[$];
  exp_t sb[$];
  exp_t e;
  logic [17:0] obs;
  multicycle_ctrl_if #(.CNT_W(32)) bus ();
  multicycle_ctrl #(.CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  assign obs = {bus.state, bus.mem_read, bus.mem_write, bus.iord, bus.ir_write, bus.pc_write,
                bus.pc_write_cond, bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                bus.reg_write, bus.mem_to_reg, bus.illegal};
  task automatic add(input logic rst, input logic [6:0] op, input logic z, input logic rdy,
                     input logic [17:0] v, input logic ret);
    stim.push_back('{rst, op, z, rdy, v, ret});
  endtask
  task automatic drive_next();
    stim_t s;
    s = stim.pop_front();
    reset = s.rst;
    bus.opcode = s.op;
    bus.zero = s.z;
    bus.mem_ready = s.rdy;
    sb.push_back('{s.v, cnt});
    cnt = s.rst ? 32'd0 : cnt + 32'(s.ret);
    cyc++;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 3; i++) add(1, OP_R, 0, 1, RST0, 0);
    add(0, OP_R, 0, 0, F_IDLE, 0);
    while (stim.size() != 0) begin
      drive_next(); #2; e = sb.pop_front();
      checks++; if (obs !== e.v) $display("FAIL reset cyc%0d strobes got %b want %b", cyc, obs, e.v); else passed++;
      checks++; if (bus.instret !== e.cnt) $display("FAIL reset cyc%0d instret got %0d want %0d", cyc, bus.instret, e.cnt); else passed++;
      @(negedge clk);
    end
  endtask
  task automatic test_alu();
    add(0, OP_R, 0, 1, F_RDY, 0); add(0, OP_R, 1, 1, DEC, 0); add(0, OP_R, 1, 1, EX_R, 0); add(0, OP_R, 0, 1, WB_R, 1);
    add(0, OP_I, 0, 1, F_RDY, 0); add(0, OP_I, 0, 0, DEC, 0); add(0, OP_I, 0, 0, EX_I, 0); add(0, OP_I, 0, 0, WB_R, 1);
    add(0, OP_I, 0, 0, F_IDLE, 0);
    while (stim.size() != 0) begin
      drive_next(); #2; e = sb.pop_front();
      checks++; if (obs !== e.v) $display("FAIL alu cyc%0d strobes got %b want %b", cyc, obs, e.v); else passed++;
      checks++; if (bus.instret !== e.cnt) $display("FAIL alu cyc%0d instret got %0d want %0d", cyc, bus.instret, e.cnt); else passed++;
      @(negedge clk);
    end
  endtask
  task automatic test_load_wait();
    add(0, OP_LD, 0, 1, F_RDY, 0); add(0, OP_LD, 0, 1, DEC, 0); add(0, OP_LD, 0, 1, EX_LS, 0);
    add(0, OP_LD, 0, 0, MEM_LD, 0); add(0, OP_LD, 0, 0, MEM_LD, 0); add(0, OP_LD, 0, 1, MEM_LD, 0);
    add(0, OP_LD, 0, 1, WB_LD, 1); add(0, OP_LD, 0, 0, F_IDLE, 0);
    while (stim.size() != 0) begin
      drive_next(); #2; e = sb.pop_front();
      checks++; if (obs !== e.v) $display("FAIL load_wait cyc%0d strobes got %b want %b", cyc, obs, e.v); else passed++;
      checks++; if (bus.instret !== e.cnt) $display("FAIL load_wait cyc%0d instret got %0d want %0d", cyc, bus.instret, e.cnt); else passed++;
      @(negedge clk);
    end
  endtask
  task automatic test_store_branch();
    add(0, OP_ST, 0, 0, F_IDLE, 0); add(0, OP_ST, 0, 1, F_RDY, 0); add(0, OP_ST, 0, 1, DEC, 0);
    add(0, OP_ST, 0, 1, EX_LS, 0); add(0, OP_ST, 0, 1, MEM_ST, 1);
    add(0, OP_BR, 1, 1, F_RDY, 0); add(0, OP_BR, 1, 1, DEC, 0); add(0, OP_BR, 1, 1, EX_BR, 1);
    add(0, OP_BR, 0, 1, F_RDY, 0); add(0, OP_BR, 0, 1, DEC, 0); add(0, OP_BR, 0, 0, EX_BR, 1);
    add(0, OP_BR, 0, 0, F_IDLE, 0);
    while (stim.size() != 0) begin
      drive_next(); #2; e = sb.pop_front();
      checks++; if (obs !== e.v) $display("FAIL store_branch cyc%0d strobes got %b want %b", cyc, obs, e.v); else passed++;
      checks++; if (bus.instret !== e.cnt) $display("FAIL store_branch cyc%0d instret got %0d want %0d", cyc, bus.instret, e.cnt); else passed++;
      @(negedge clk);
    end
  endtask
  task automatic test_illegal();
    add(0, OP_BAD, 0, 1, F_RDY, 0); add(0, OP_BAD, 0, 1, DEC_ILL, 1); add(0, OP_BAD, 0, 0, F_IDLE, 0);
    while (stim.size() != 0) begin
      drive_next(); #2; e = sb.pop_front();
      checks++; if (obs !== e.v) $display("FAIL illegal cyc%0d strobes got %b want %b", cyc, obs, e.v); else passed++;
      checks++; if (bus.instret !== e.cnt) $display("FAIL illegal cyc%0d instret got %0d want %0d", cyc, bus.instret, e.cnt); else passed++;
      @(negedge clk);
    end
  endtask
  task automatic test_back_to_back();
    add(0, OP_R, 0, 1, F_RDY, 0); add(0, OP_R, 0, 1, DEC, 0); add(0, OP_R, 0, 1, EX_R, 0); add(0, OP_R, 0, 1, WB_R, 1);
    add(0, OP_LD, 0, 1, F_RDY, 0); add(0, OP_LD, 0, 1, DEC, 0); add(0, OP_LD, 0, 1, EX_LS, 0);
    add(0, OP_LD, 0, 1, MEM_LD, 0); add(0, OP_LD, 0, 1, WB_LD, 1);
    add(0, OP_BAD, 0, 1, F_RDY, 0); add(0, OP_BAD, 0, 1, DEC_ILL, 1); add(0, OP_BAD, 0, 0, F_IDLE, 0);
    while (stim.size() != 0) begin
      drive_next(); #2; e = sb.pop_front();
      checks++; if (obs !== e.v) $display("FAIL back_to_back cyc%0d strobes got %b want %b", cyc, obs, e.v); else passed++;
      checks++; if (bus.instret !== e.cnt) $display("FAIL back_to_back cyc%0d instret got %0d want %0d", cyc, bus.instret, e.cnt); else passed++;
      @(negedge clk);
    end
  endtask
  task automatic test_reset_store();
    add(0, OP_ST, 0, 1, F_RDY, 0); add(0, OP_ST, 0, 1, DEC, 0); add(0, OP_ST, 0, 1, EX_LS, 0);
    add(0, OP_ST, 0, 0, MEM_ST, 0); add(1, OP_ST, 0, 0, RST_MEM, 0); add(0, OP_ST, 0, 0, F_IDLE, 0);
    while (stim.size() != 0) begin
      drive_next(); #2; e = sb.pop_front();
      checks++; if (obs !== e.v) $display("FAIL reset_store cyc%0d strobes got %b want %b", cyc, obs, e.v); else passed++;
      checks++; if (bus.instret !== e.cnt) $display("FAIL reset_store cyc%0d instret got %0d want %0d", cyc, bus.instret, e.cnt); else passed++;
      @(negedge clk);
    end
  endtask
  initial begin
    reset = 1'b1;
    bus.opcode = OP_R;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_alu();
    test_load_wait();
    test_store_branch();
    test_illegal();
    test_back_to_back();
    test_reset_store();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
